// File: rtl/dmem_ctrl.sv
// Data memory for the MEM stage: byte/halfword/word stores with per-lane
// enables, sign/zero-extending loads with a one-cycle registered result,
// misalignment fault detection and a clear sweep after reset.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | zeroing word clr_idx_q each cycle; requests ignored, busy=1
//   ST_READY | servicing load/store requests, one per cycle
module dmem_ctrl #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        rvalid,
  output logic        fault,
  output logic        busy
);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic [31:0]      rd_q;
  logic             rvalid_q;
  logic             fault_q;
  logic [31:0]      mem_q [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             misaligned;
  logic             accept;
  logic             do_load;
  logic             do_store;
  logic             do_fault;
  logic             clr_we;
  logic [31:0]      rdata_word;
  logic [31:0]      shifted;
  logic [31:0]      load_d;
  logic [3:0]       be_d;
  logic [31:0]      wdata_d;

  // Address bits above the word index are deliberately ignored (aliasing).
  logic unused_addr_hi;
  assign unused_addr_hi = ^a[31:IDX_W+2];

  assign idx = a[IDX_W+1:2];

  // Request qualification: only in READY and never in a reset cycle.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = |a[1:0];
      default: misaligned = 1'b1;
    endcase
    accept   = req && (state_q == ST_READY) && !reset;
    do_fault = accept && misaligned;
    do_store = accept && we && !misaligned;
    do_load  = accept && !we && !misaligned;
    clr_we   = (state_q == ST_CLEAR) && !reset;
  end

  // Load path: move the addressed lane(s) down to bit 0, then extend.
  always_comb begin
    rdata_word = mem_q[idx];
    shifted    = rdata_word >> {a[1:0], 3'b000};
    load_d     = '0;
    case (size)
      2'b00:   load_d = {{24{sext & shifted[7]}}, shifted[7:0]};
      2'b01:   load_d = {{16{sext & shifted[15]}}, shifted[15:0]};
      2'b10:   load_d = rdata_word;
      default: load_d = '0;
    endcase
  end

  // Store path: replicate the right-justified data and pick lanes by size.
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = wd;
    case (size)
      2'b00: begin
        be_d    = 4'b0001 << a[1:0];
        wdata_d = {4{wd[7:0]}};
      end
      2'b01: begin
        be_d    = a[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wd[15:0]}};
      end
      2'b10: begin
        be_d    = 4'b1111;
        wdata_d = wd;
      end
      default: begin
        be_d    = 4'b0000;
        wdata_d = wd;
      end
    endcase
  end

  // RAM array: the clear sweep has priority; requests cannot coexist with it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx_q] <= '0;
    end else if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) mem_q[idx][8*i +: 8] <= wdata_d[8*i +: 8];
      end
    end
  end

  // Controller FSM with registered load result and fault pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      rd_q      <= '0;
      rvalid_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      rvalid_q <= do_load;
      fault_q  <= do_fault;
      rd_q     <= do_load ? load_d : 32'h0;
      case (state_q)
        ST_CLEAR: begin
          clr_idx_q <= clr_idx_q + IDX_W'(1);
          if (clr_idx_q == IDX_W'(DEPTH - 1)) state_q <= ST_READY;
        end
        ST_READY: begin
          clr_idx_q <= '0;
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  assign rd     = rd_q;
  assign rvalid = rvalid_q;
  assign fault  = fault_q;
  assign busy   = (state_q == ST_CLEAR) || reset;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized traffic checked
// against a byte-addressed reference memory.
module tb_dmem_ctrl;

  localparam int DEPTH = 64;
  localparam int NBYTE = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        rvalid;
  logic        fault;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] ref_mem [NBYTE];

  dmem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .size   (size),
    .sext   (sext),
    .a      (a),
    .wd     (wd),
    .rd     (rd),
    .rvalid (rvalid),
    .fault  (fault),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < NBYTE; i++) ref_mem[i] = 8'h00;
  endtask

  function automatic bit ref_bad(input logic [1:0] sz, input logic [31:0] ad);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && ad[0]) return 1'b1;
    if (sz == 2'b10 && ad[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx, input logic [31:0] ad);
    int          n;
    int          base;
    longint      v;
    n    = 1 << sz;
    base = int'(ad) % NBYTE;
    if (base < 0) base += NBYTE;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[(base + i) % NBYTE]) << (8 * i);
    if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] d);
    int n;
    int base;
    n    = 1 << sz;
    base = int'(ad[7:0]);
    for (int i = 0; i < n; i++) ref_mem[(base + i) % NBYTE] = d[8*i +: 8];
  endtask

  // One request, checked in the cycle after the edge that accepts it.
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] ad, input logic [31:0] d,
                        output logic [31:0] rd_obs);
    bit          bad;
    logic [31:0] exp_rd;
    bad    = ref_bad(sz, ad);
    exp_rd = (!w && !bad) ? ref_load(sz, sx, ad) : 32'h0;
    req = 1'b1; we = w; size = sz; sext = sx; a = ad; wd = d;
    step();
    req = 1'b0;
    chk("fault", {31'b0, fault}, {31'b0, bad});
    chk("rvalid", {31'b0, rvalid}, {31'b0, (!w && !bad)});
    chk("rd", rd, exp_rd);
    if (w && !bad) ref_store(sz, ad, d);
    rd_obs = rd;
  endtask

  task automatic idle();
    req = 1'b0;
    step();
    chk("idle_rvalid", {31'b0, rvalid}, 32'h0);
    chk("idle_fault", {31'b0, fault}, 32'h0);
  endtask

  // Count busy cycles while hammering the DUT with requests that must be ignored.
  task automatic poll_busy(input string tag);
    int n;
    int spur;
    n = 0;
    spur = 0;
    size = 2'b10; a = 32'h0000_00FC; wd = 32'hFFFF_FFFF; sext = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      req = 1'b1;
      we  = n[0];
      if (rvalid !== 1'b0 || fault !== 1'b0) spur++;
      n++;
      step();
    end
    req = 1'b0;
    chk({tag, "_len"}, n, DEPTH);
    chk({tag, "_spurious"}, spur, 0);
    ref_clear();
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
    a = 32'h0; wd = 32'h0;
    ref_clear();
    repeat (3) step();
    chk("rst_rd", rd, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);

    // Clear sweep, then verify the last word stayed zero.
    reset = 1'b0;
    poll_busy("sweep");
    access(1'b0, 2'b10, 1'b0, 32'h0000_00FC, 32'h0, r);
    chk("sweep_ld_fc", r, 32'h0);

    // Byte lanes.
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, r);
    access(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, r);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    chk("byte_word", r, 32'h11AA_3344);
    access(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, r);
    chk("byte_sext", r, 32'hFFFF_FFAA);
    access(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, r);
    chk("byte_zext", r, 32'h0000_00AA);

    // Halfword.
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h5566_7788, r);
    access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, r);
    access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, r);
    chk("half_sext", r, 32'hFFFF_8001);
    access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, r);
    chk("half_low", r, 32'h0000_7788);

    // Misalignment and illegal size; memory must be untouched.
    access(1'b1, 2'b10, 1'b0, 32'h13, 32'hCAFE_F00D, r);
    access(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, r);
    access(1'b1, 2'b11, 1'b0, 32'h10, 32'hCAFE_F00D, r);
    access(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, r);
    idle();
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    chk("mis_keep", r, 32'h11AA_3344);

    // Aliasing, store-then-load back to back, and a run of loads.
    access(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, r);
    access(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, r);
    chk("alias", r, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) access(1'b0, 2'b10, 1'b0, 32'h10 + 32'(4 * i), 32'h0, r);
    idle();

    // Reset at sweep index 30 restarts the full sweep.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (30) step();
    chk("mid_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    step();
    chk("mid_rst_busy", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    poll_busy("resweep");

    // Reset right after an accepted load clears the pending result.
    access(1'b1, 2'b10, 1'b0, 32'h40, 32'h0BAD_F00D, r);
    access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, r);
    reset = 1'b1;
    step();
    chk("rst_ld_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_ld_rd", rd, 32'h0);
    reset = 1'b0;
    poll_busy("sweep3");

    // Load requested in the same cycle as reset is dropped.
    req = 1'b1; we = 1'b0; size = 2'b10; a = 32'h0; reset = 1'b1;
    step();
    req = 1'b0;
    chk("rst_req_rvalid", {31'b0, rvalid}, 32'h0);
    reset = 1'b0;
    poll_busy("sweep4");

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idle();
      end else begin
        logic [31:0] ad;
        ad = $urandom();
        if ($urandom_range(0, 3) != 0) ad = ad & 32'hFFFF_FF3F;
        access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ad, $urandom(), r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data memory for the pipelined core's MEM stage. It replaces the word-only, combinational-read data RAM with four additions: byte, halfword and word stores with per-lane write enables; sign- or zero-extending loads with a registered one-cycle read; misaligned-access fault detection; and a hardware clear sweep after reset. It sits between the MEM-stage address/data registers and the WB-stage result mux.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; must be a power of 2 and ≥ 2.
- `IDX_W`, $clog2(DEPTH): word-index width. Derived; do not override.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, 1: access request, valid this cycle.
- `we`, in, 1: 1 = store, 0 = load. Qualified by `req`.
- `size`, in, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `sext`, in, 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `a`, in, 32: byte address.
- `wd`, in, 32: store data, right-justified.
- `rd`, out, 32: load result, valid when `rvalid` = 1, otherwise 0.
- `rvalid`, out, 1: one-cycle pulse, load result available.
- `fault`, out, 1: one-cycle pulse, misaligned or illegal access.
- `busy`, out, 1: clear sweep in progress; requests are ignored.

## Operation
- **Addressing**
  - Word index = `a[IDX_W+1:2]`.
  - Bits above the index are ignored, so addresses alias modulo 4·DEPTH.
  - Byte lanes are little-endian: lane n holds bits [8n+7:8n].
- **State machine**
  - States are CLEAR and READY. CLEAR is the reset state.
  - CLEAR: a counter `clr_idx` starts at 0 and writes 32'h0 to word `clr_idx` each cycle. After writing word DEPTH-1 the block moves to READY.
  - READY: the block services requests.
  - `busy` = 1 in CLEAR and while `reset` is high.
- **Alignment check**
  - Halfword requires `a[0]` = 0.
  - Word requires `a[1:0]` = 0.
  - `size` = 11 is always illegal.
  - A failing access is a fault.
- **Store** (`req` & `we` & READY & no fault)
  - Byte: lane `a[1:0]` ← `wd[7:0]`.
  - Halfword: lanes {2·`a[1]`+1, 2·`a[1]`} ← `wd[15:0]`.
  - Word: all lanes ← `wd`.
  - Unselected lanes keep their value. A store never asserts `rvalid`.
- **Load** (`req` & ~`we` & READY & no fault)
  - The selected word is read at the request edge.
  - The selected lane(s) are shifted to bit 0 and extended per `sext`.
  - The result is registered into `rd`, and `rvalid` is set for one cycle.
- **Fault**
  - No RAM write occurs. `fault` = 1 in the next cycle with `rvalid` = 0 and `rd` = 0. This applies to both loads and stores.
- **Requests while busy**: fully ignored. No write, no `rvalid`, no `fault`.
- **Reset mid-operation**
  - Reset during CLEAR restarts the sweep at index 0.
  - Reset during READY discards any pending `rvalid`/`fault` and re-enters CLEAR.
  - RAM contents are not guaranteed until the sweep completes.

## Timing
- Reset values: `rd` = 0, `rvalid` = 0, `fault` = 0, `busy` = 1, state = CLEAR, `clr_idx` = 0.
- Clear sweep:
  - With `reset` deasserted at edge E0, word k is cleared at edge E0+k for k = 0..DEPTH-1.
  - `busy` reads 0 from the cycle after edge E0+DEPTH-1, i.e. DEPTH cycles after reset release.
  - A `req` is first accepted in the cycle where `busy` = 0.
- Load latency is 1 cycle:
  - `req` sampled at edge N gives `rvalid`/`rd` valid in the cycle after edge N.
  - Both return to 0 at edge N+1 unless another load is accepted at that edge.
- Back-to-back:
  - One access is accepted per cycle.
  - A store at edge N followed by a load to the same word at edge N+1 returns the new data.
  - Consecutive loads give `rvalid` high continuously.
- `fault` has the same 1-cycle latency as `rvalid`. The two are mutually exclusive.

## Test plan
- **Clear sweep**: DEPTH=64. Release reset, then poll `busy`.
  - `busy` = 1 for exactly 64 cycles, then 0.
  - A word load from 0x0FC returns 0 with `rvalid` 1 cycle later.
  - A request during `busy` produces no `rvalid` and no write.
- **Byte stores and loads**: store word 0x11223344 @0x10, then byte 0xAA @0x12.
  - Word load @0x10 gives 0x11AA3344.
  - Byte load @0x12 with `sext` = 1 gives 0xFFFFFFAA; with `sext` = 0 gives 0x000000AA.
- **Halfword**: store half 0x8001 @0x22.
  - Half load @0x22 with `sext` = 1 gives 0xFFFF8001.
  - Half load @0x20 gives the untouched lower half.
- **Misalignment**: word store @0x13, half load @0x05, and `size` = 11.
  - Each gives `fault` = 1 for one cycle, `rvalid` = 0 and `rd` = 0.
  - A word load @0x10 afterwards still returns its prior value.
- **Aliasing and back-to-back**: DEPTH=64. Store word 0xDEADBEEF @0x104, then load @0x004 on the very next cycle.
  - Returns 0xDEADBEEF.
  - 4 consecutive loads give `rvalid` high for 4 cycles.
- **Reset mid-sweep and mid-load**: assert `reset` at sweep index 30, release it, then check `busy`.
  - `busy` stays 1 for a further full 64 cycles.
  - `reset` in the cycle after a load request suppresses that load's `rvalid`.
